// File: rtl/ram_arb_pkg.sv
// Shared defaults, port indices and the response tag for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int AW_DEFAULT    = 13;
    localparam int DEPTH_DEFAULT = 6144;
    localparam int WW_DEFAULT    = 4;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    // One in-flight response: which port it belongs to and whether the address was out of range.
    typedef struct packed {
        logic valid;
        logic port;
        logic err;
    } resp_tag_t;

endpackage

// File: rtl/ram_arbiter_2p_rr.sv
// Two-way round-robin arbiter: combinational grant, pointer flop moves to the other port after each grant.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       ptr;
    logic [1:0] req_live;

    // Requests are ignored while reset is asserted so no grant can leak out of reset.
    assign req_live = req & {2{rst_n}};

    always_comb begin
        gnt = req_live;
        if (req_live == 2'b11) begin
            gnt = (ptr == P_DMA) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= P_CPU;
        end else if (gnt[0]) begin
            ptr <= P_DMA;
        end else if (gnt[1]) begin
            ptr <= P_CPU;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Two-port (CPU/DMA) front end for a single-port synchronous RAM: arbitration, range check,
// RAM signal muxing and a one-deep response pipeline.
module ram_arbiter_2p
    import ram_arb_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WW    = WW_DEFAULT
) (
    input  logic          CLK,
    input  logic          RESETn,

    input  logic          p0_req,
    input  logic [WW-1:0] p0_we,
    input  logic [AW-1:0] p0_a,
    input  logic [31:0]   p0_di,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_do,
    output logic          p0_err,

    input  logic          p1_req,
    input  logic [WW-1:0] p1_we,
    input  logic [AW-1:0] p1_a,
    input  logic [31:0]   p1_di,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_do,
    output logic          p1_err,

    output logic          ram_EN,
    output logic [WW-1:0] ram_WE,
    output logic [AW-1:0] ram_A,
    output logic [31:0]   ram_Di,
    input  logic [31:0]   ram_Do
);

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [1:0]    gnt;
    logic          any_gnt;
    logic          sel;
    logic [WW-1:0] sel_we;
    logic [AW-1:0] sel_a;
    logic [31:0]   sel_di;
    logic          in_range;
    logic [AW-1:0] hold_a;
    logic [31:0]   hold_di;
    resp_tag_t     tag;
    logic          resp_rd;
    logic          rv0;
    logic          rv1;

    rr_arbiter2 u_arb (
        .clk   (CLK),
        .rst_n (RESETn),
        .req   ({p1_req, p0_req}),
        .gnt   (gnt)
    );

    assign p0_gnt  = gnt[0];
    assign p1_gnt  = gnt[1];
    assign any_gnt = |gnt;
    assign sel     = gnt[1];

    assign sel_we = (sel == P_DMA) ? p1_we : p0_we;
    assign sel_a  = (sel == P_DMA) ? p1_a  : p0_a;
    assign sel_di = (sel == P_DMA) ? p1_di : p0_di;

    assign in_range = ({1'b0, sel_a} < DEPTH_LIM);

    // Out-of-range grants never touch the RAM; address and data lines park on the last grant when idle.
    assign ram_EN = any_gnt & in_range;
    assign ram_WE = ram_EN ? sel_we : '0;
    assign ram_A  = any_gnt ? sel_a  : hold_a;
    assign ram_Di = any_gnt ? sel_di : hold_di;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            hold_a  <= '0;
            hold_di <= '0;
            tag     <= '0;
            resp_rd <= 1'b0;
        end else begin
            tag.valid <= any_gnt;
            tag.port  <= sel;
            tag.err   <= any_gnt & ~in_range;
            resp_rd   <= ram_EN & (sel_we == '0);
            if (any_gnt) begin
                hold_a  <= sel_a;
                hold_di <= sel_di;
            end
        end
    end

    // ram_Do is only meaningful for an in-range read; writes and errors return zero data.
    assign rv0 = tag.valid & (tag.port == P_CPU);
    assign rv1 = tag.valid & (tag.port == P_DMA);

    assign p0_rvalid = rv0;
    assign p1_rvalid = rv1;
    assign p0_err    = rv0 & tag.err;
    assign p1_err    = rv1 & tag.err;
    assign p0_do     = (rv0 & resp_rd) ? ram_Do : '0;
    assign p1_do     = (rv1 & resp_rd) ? ram_Do : '0;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Self-checking bench for ram_arbiter_2p: behavioural RAM, directed scenarios and a randomized
// two-requester run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_ram_arbiter_2p;

    localparam int AW    = 13;
    localparam int DEPTH = 6144;
    localparam int WW    = 4;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          p0_req, p1_req;
    logic [WW-1:0] p0_we, p1_we;
    logic [AW-1:0] p0_a, p1_a;
    logic [31:0]   p0_di, p1_di;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0]   p0_do, p1_do;
    logic          ram_EN;
    logic [WW-1:0] ram_WE;
    logic [AW-1:0] ram_A;
    logic [31:0]   ram_Di;
    logic [31:0]   ram_Do;

    int checks   = 0;
    int failures = 0;

    ram_arbiter_2p #(.AW(AW), .DEPTH(DEPTH), .WW(WW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_a(p0_a), .p0_di(p0_di),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_do(p0_do), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_a(p1_a), .p1_di(p1_di),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_do(p1_do), .p1_err(p1_err),
        .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do)
    );

    always #5 CLK = ~CLK;

    // Synchronous single-port RAM: read data appears one cycle after ram_EN.
    logic [31:0] ram_mem [DEPTH];
    always @(posedge CLK) begin
        if (ram_EN) begin
            if (int'(ram_A) < DEPTH) begin
                for (int b = 0; b < WW; b++)
                    if (ram_WE[b]) ram_mem[ram_A][8*b +: 8] = ram_Di[8*b +: 8];
                ram_Do <= ram_mem[ram_A];
            end else begin
                ram_Do <= 32'hBAD0_BAD0;
            end
        end
    end

    // Reference model: a word array, the port that wins the next tie, and the one pending response.
    logic [31:0]   ref_mem [DEPTH];
    int            favour;
    logic          pend_valid;
    int            pend_port;
    logic          pend_err;
    logic [31:0]   pend_do;
    logic [AW-1:0] last_a;
    logic [31:0]   last_di;

    logic          exp_g0, exp_g1, exp_en;
    logic [WW-1:0] exp_we;
    logic [AW-1:0] exp_a;
    logic [31:0]   exp_di;
    logic          exp_rv0, exp_rv1, exp_er0, exp_er1;
    logic [31:0]   exp_do0, exp_do1;

    task automatic model_reset();
        favour     = 0;
        pend_valid = 1'b0;
        pend_port  = 0;
        pend_err   = 1'b0;
        pend_do    = '0;
        last_a     = '0;
        last_di    = '0;
    endtask

    task automatic model_step();
        int            gp;
        logic [WW-1:0] wg;
        logic [AW-1:0] ag;
        logic [31:0]   dg;
        logic          inr;
        gp = -1;
        if (p0_req && p1_req) gp = favour;
        else if (p0_req)      gp = 0;
        else if (p1_req)      gp = 1;
        exp_g0  = (gp == 0);
        exp_g1  = (gp == 1);
        exp_rv0 = pend_valid && (pend_port == 0);
        exp_rv1 = pend_valid && (pend_port == 1);
        exp_er0 = exp_rv0 && pend_err;
        exp_er1 = exp_rv1 && pend_err;
        exp_do0 = exp_rv0 ? pend_do : 32'h0;
        exp_do1 = exp_rv1 ? pend_do : 32'h0;
        wg  = (gp == 1) ? p1_we : p0_we;
        ag  = (gp == 1) ? p1_a  : p0_a;
        dg  = (gp == 1) ? p1_di : p0_di;
        inr = int'(ag) < DEPTH;
        exp_en = (gp >= 0) && inr;
        exp_we = exp_en ? wg : '0;
        if (gp >= 0) begin
            last_a  = ag;
            last_di = dg;
            favour  = 1 - gp;
        end
        exp_a      = last_a;
        exp_di     = last_di;
        pend_valid = (gp >= 0);
        pend_port  = (gp < 0) ? 0 : gp;
        pend_err   = !inr;
        pend_do    = 32'h0;
        if (gp >= 0 && inr) begin
            if (wg == '0) pend_do = ref_mem[ag];
            else
                for (int b = 0; b < WW; b++)
                    if (wg[b]) ref_mem[ag][8*b +: 8] = dg[8*b +: 8];
        end
    endtask

    // Drives one cycle from the falling edge and samples 2 ns later, well before the rising edge.
    task automatic drive_cycle(input logic r0, input logic [WW-1:0] w0, input logic [AW-1:0] a0,
                               input logic [31:0] d0, input logic r1, input logic [WW-1:0] w1,
                               input logic [AW-1:0] a1, input logic [31:0] d1);
        @(negedge CLK);
        p0_req = r0; p0_we = w0; p0_a = a0; p0_di = d0;
        p1_req = r1; p1_we = w1; p1_a = a1; p1_di = d1;
        #2;
        model_step();
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        p0_req = 1'b0; p1_req = 1'b0;
        RESETn = 1'b0;
        model_reset();
        @(negedge CLK);
        RESETn = 1'b1;
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        p0_req = 1'b1; p0_we = 4'hF; p0_a = 13'h0123; p0_di = 32'h12345678;
        p1_req = 1'b1; p1_we = 4'h3; p1_a = 13'h0456; p1_di = 32'h9ABCDEF0;
        #2;
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b00) begin
            failures++; $display("[TB] FAIL reset_gnt: got %b want 00", {p0_gnt, p1_gnt});
        end
        checks++;
        if ({ram_EN, ram_WE, ram_A, ram_Di} !== {1'b0, 4'h0, 13'h0, 32'h0}) begin
            failures++; $display("[TB] FAIL reset_ram: got EN=%b WE=%h A=%h Di=%h want all zero",
                                 ram_EN, ram_WE, ram_A, ram_Di);
        end
        checks++;
        if ({p0_rvalid, p1_rvalid, p0_err, p1_err, p0_do, p1_do} !== 68'h0) begin
            failures++; $display("[TB] FAIL reset_resp: got rv=%b%b err=%b%b do0=%h do1=%h want zero",
                                 p0_rvalid, p1_rvalid, p0_err, p1_err, p0_do, p1_do);
        end
        @(negedge CLK);
        p0_req = 1'b0; p1_req = 1'b0;
        RESETn = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        drive_cycle(1'b1, 4'hF, 13'h0010, 32'hDEADBEEF, 1'b0, '0, '0, '0);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            failures++; $display("[TB] FAIL wr_gnt: got %b want 10", {p0_gnt, p1_gnt});
        end
        checks++;
        if ({ram_EN, ram_WE, ram_A, ram_Di} !== {1'b1, 4'hF, 13'h0010, 32'hDEADBEEF}) begin
            failures++; $display("[TB] FAIL wr_ram: got EN=%b WE=%h A=%h Di=%h want 1 F 0010 DEADBEEF",
                                 ram_EN, ram_WE, ram_A, ram_Di);
        end
        drive_cycle(1'b1, 4'h0, 13'h0010, 32'h0, 1'b0, '0, '0, '0);
        checks++;
        if ({p0_gnt, ram_EN, ram_WE} !== {1'b1, 1'b1, 4'h0}) begin
            failures++; $display("[TB] FAIL rd_gnt: got gnt=%b EN=%b WE=%h want 1 1 0", p0_gnt, ram_EN, ram_WE);
        end
        checks++;
        if ({p0_rvalid, p0_err, p0_do, p1_rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++; $display("[TB] FAIL wr_resp: got rv0=%b err0=%b do0=%h rv1=%b want 1 0 0 0",
                                 p0_rvalid, p0_err, p0_do, p1_rvalid);
        end
        idle_cycle();
        checks++;
        if ({p0_rvalid, p0_err, p0_do} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            failures++; $display("[TB] FAIL rd_resp: got rv0=%b err0=%b do0=%h want 1 0 DEADBEEF",
                                 p0_rvalid, p0_err, p0_do);
        end
        idle_cycle();
        checks++;
        if ({p0_rvalid, p0_do} !== 33'h0) begin
            failures++; $display("[TB] FAIL resp_pulse: got rv0=%b do0=%h want 0 0", p0_rvalid, p0_do);
        end
    endtask

    task automatic test_contention();
        // Leave the pointer favouring P1 so the reset really has to move it back.
        drive_cycle(1'b1, 4'h0, 13'h0100, 32'h0, 1'b0, '0, '0, '0);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive_cycle(1'b1, 4'h0, 13'h0010, 32'h0, 1'b1, 4'h0, 13'h0020, 32'h0);
            else       idle_cycle();
            if (i < 6) begin
                checks++;
                if ({p0_gnt, p1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++; $display("[TB] FAIL cont_gnt[%0d]: got %b want %b", i, {p0_gnt, p1_gnt},
                                         (i % 2 == 0) ? 2'b10 : 2'b01);
                end
            end
            if (i > 0) begin
                checks++;
                if ({p0_rvalid, p1_rvalid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                    failures++; $display("[TB] FAIL cont_rv[%0d]: got %b want %b", i, {p0_rvalid, p1_rvalid},
                                         (i % 2 == 1) ? 2'b10 : 2'b01);
                end
                checks++;
                if ({p0_do, p1_do} !== ((i % 2 == 1) ? {32'hDEADBEEF, 32'h0} : 64'h0)) begin
                    failures++; $display("[TB] FAIL cont_data[%0d]: got do0=%h do1=%h", i, p0_do, p1_do);
                end
            end
        end
    endtask

    task automatic test_byte_enables();
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'hF, 13'h17FF, 32'h11223344);
        checks++;
        if ({p1_gnt, ram_EN, ram_WE, ram_A} !== {1'b1, 1'b1, 4'hF, 13'h17FF}) begin
            failures++; $display("[TB] FAIL be_full: got gnt=%b EN=%b WE=%h A=%h", p1_gnt, ram_EN, ram_WE, ram_A);
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'b0010, 13'h17FF, 32'h0000AB00);
        checks++;
        if ({p1_gnt, ram_WE, ram_Di} !== {1'b1, 4'b0010, 32'h0000AB00}) begin
            failures++; $display("[TB] FAIL be_partial: got gnt=%b WE=%b Di=%h want 1 0010 0000AB00",
                                 p1_gnt, ram_WE, ram_Di);
        end
        drive_cycle(1'b1, 4'h0, 13'h17FF, 32'h0, 1'b0, '0, '0, '0);
        idle_cycle();
        checks++;
        if ({p0_rvalid, p0_err, p0_do} !== {1'b1, 1'b0, 32'h1122AB44}) begin
            failures++; $display("[TB] FAIL be_read: got rv0=%b err0=%b do0=%h want 1 0 1122AB44",
                                 p0_rvalid, p0_err, p0_do);
        end
    endtask

    task automatic test_out_of_range();
        drive_cycle(1'b1, 4'h0, 13'h1800, 32'h0, 1'b0, '0, '0, '0);
        checks++;
        if ({p0_gnt, ram_EN, ram_WE} !== {1'b1, 1'b0, 4'h0}) begin
            failures++; $display("[TB] FAIL oor_grant: got gnt=%b EN=%b WE=%h want 1 0 0", p0_gnt, ram_EN, ram_WE);
        end
        drive_cycle(1'b1, 4'hF, 13'h1FFF, 32'hFFFFFFFF, 1'b0, '0, '0, '0);
        checks++;
        if ({p0_rvalid, p0_err, p0_do} !== {1'b1, 1'b1, 32'h0}) begin
            failures++; $display("[TB] FAIL oor_resp: got rv0=%b err0=%b do0=%h want 1 1 0", p0_rvalid, p0_err, p0_do);
        end
        checks++;
        if ({p0_gnt, ram_EN, ram_WE} !== {1'b1, 1'b0, 4'h0}) begin
            failures++; $display("[TB] FAIL oor_write: got gnt=%b EN=%b WE=%h want 1 0 0", p0_gnt, ram_EN, ram_WE);
        end
        idle_cycle();
        checks++;
        if ({p0_rvalid, p0_err, p0_do} !== {1'b1, 1'b1, 32'h0}) begin
            failures++; $display("[TB] FAIL oor_wresp: got rv0=%b err0=%b do0=%h want 1 1 0", p0_rvalid, p0_err, p0_do);
        end
    endtask

    task automatic test_reset_mid_read();
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'h0, 13'h17FF, 32'h0);
        checks++;
        if (p1_gnt !== 1'b1) begin
            failures++; $display("[TB] FAIL rst_rd_gnt: got %b want 1", p1_gnt);
        end
        @(negedge CLK);
        p0_req = 1'b0; p1_req = 1'b0;
        RESETn = 1'b0;
        model_reset();
        #2;
        checks++;
        if (p1_rvalid !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_discard: got rv1=%b want 0", p1_rvalid);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_cycle();
            checks++;
            if ({p0_rvalid, p1_rvalid} !== 2'b00) begin
                failures++; $display("[TB] FAIL rst_no_resp[%0d]: got %b want 00", i, {p0_rvalid, p1_rvalid});
            end
        end
        drive_cycle(1'b1, 4'h0, 13'h0010, 32'h0, 1'b1, 4'h0, 13'h0020, 32'h0);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            failures++; $display("[TB] FAIL rst_first_gnt: got %b want 10", {p0_gnt, p1_gnt});
        end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 4'h0, 13'h0020, 32'h0);
        idle_cycle();
    endtask

    task automatic test_idle();
        drive_cycle(1'b1, 4'hF, 13'h0ABC, 32'hCAFEF00D, 1'b0, '0, '0, '0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 4'($urandom), 13'($urandom), $urandom, 1'b0, 4'($urandom), 13'($urandom), $urandom);
            checks++;
            if ({ram_EN, ram_WE, ram_A, ram_Di} !== {1'b0, 4'h0, 13'h0ABC, 32'hCAFEF00D}) begin
                failures++; $display("[TB] FAIL idle_hold[%0d]: got EN=%b WE=%h A=%h Di=%h want 0 0 0ABC CAFEF00D",
                                     i, ram_EN, ram_WE, ram_A, ram_Di);
            end
        end
        drive_cycle(1'b1, 4'h0, 13'h0010, 32'h0, 1'b1, 4'h0, 13'h0020, 32'h0);
        checks++;
        if ({p0_gnt, p1_gnt} !== 2'b01) begin
            failures++; $display("[TB] FAIL idle_ptr: got %b want 01", {p0_gnt, p1_gnt});
        end
        drive_cycle(1'b1, 4'h0, 13'h0010, 32'h0, 1'b0, '0, '0, '0);
        idle_cycle();
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 9))
            0:       return 13'(6144 + $urandom_range(0, 2047));
            1:       return 13'h17FF;
            default: return 13'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic test_random();
        logic          r0, r1;
        logic [WW-1:0] w0, w1;
        logic [AW-1:0] a0, a1;
        logic [31:0]   d0, d1;
        int            wait0, wait1;
        r0 = 1'b0; r1 = 1'b0; w0 = '0; w1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        wait0 = 0; wait1 = 0;
        for (int c = 0; c < 300; c++) begin
            if (!r0 && $urandom_range(0, 2) != 0) begin
                r0 = 1'b1; w0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                a0 = pick_addr(); d0 = $urandom; wait0 = 0;
            end
            if (!r1 && $urandom_range(0, 2) != 0) begin
                r1 = 1'b1; w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                a1 = pick_addr(); d1 = $urandom; wait1 = 0;
            end
            if (r0 && wait0 > 0 && $urandom_range(0, 19) == 0) r0 = 1'b0;
            if (r1 && wait1 > 0 && $urandom_range(0, 19) == 0) r1 = 1'b0;
            drive_cycle(r0, w0, a0, d0, r1, w1, a1, d1);
            checks++;
            if ({p0_gnt, p1_gnt} !== {exp_g0, exp_g1}) begin
                failures++; $display("[TB] FAIL rnd_gnt[%0d]: got %b want %b", c, {p0_gnt, p1_gnt}, {exp_g0, exp_g1});
            end
            checks++;
            if ({ram_EN, ram_WE} !== {exp_en, exp_we}) begin
                failures++; $display("[TB] FAIL rnd_ram_ctl[%0d]: got EN=%b WE=%h want %b %h", c, ram_EN, ram_WE,
                                     exp_en, exp_we);
            end
            if (exp_en) begin
                checks++;
                if ({ram_A, ram_Di} !== {exp_a, exp_di}) begin
                    failures++; $display("[TB] FAIL rnd_ram_ad[%0d]: got A=%h Di=%h want %h %h", c, ram_A, ram_Di,
                                         exp_a, exp_di);
                end
            end
            checks++;
            if ({p0_rvalid, p0_err, p0_do} !== {exp_rv0, exp_er0, exp_do0}) begin
                failures++; $display("[TB] FAIL rnd_p0_resp[%0d]: got rv=%b err=%b do=%h want %b %b %h", c,
                                     p0_rvalid, p0_err, p0_do, exp_rv0, exp_er0, exp_do0);
            end
            checks++;
            if ({p1_rvalid, p1_err, p1_do} !== {exp_rv1, exp_er1, exp_do1}) begin
                failures++; $display("[TB] FAIL rnd_p1_resp[%0d]: got rv=%b err=%b do=%h want %b %b %h", c,
                                     p1_rvalid, p1_err, p1_do, exp_rv1, exp_er1, exp_do1);
            end
            if (r0) begin
                if (exp_g0) r0 = 1'b0;
                else        wait0++;
            end
            if (r1) begin
                if (exp_g1) r1 = 1'b0;
                else        wait1++;
            end
            checks++;
            if (wait0 > 1 || wait1 > 1) begin
                failures++; $display("[TB] FAIL rnd_starve[%0d]: got waits %0d/%0d want at most 1", c, wait0, wait1);
            end
        end
        idle_cycle();
        checks++;
        if ({p0_rvalid, p0_do, p1_rvalid, p1_do} !== {exp_rv0, exp_do0, exp_rv1, exp_do1}) begin
            failures++; $display("[TB] FAIL rnd_drain: got rv=%b%b do0=%h do1=%h want %b%b %h %h", p0_rvalid,
                                 p1_rvalid, p0_do, p1_do, exp_rv0, exp_rv1, exp_do0, exp_do1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        model_reset();
        test_reset();
        test_write_read();
        test_contention();
        test_byte_enables();
        test_out_of_range();
        test_reset_mid_read();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
